wb_irq_ctrl: RTL and testbench

WB_IRQ_CTRL -- requirements
Module: wb_irq_ctrl

---
 rtl/wb_irq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_wb_irq_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_irq_ctrl.sv
// Wishbone interrupt controller: per-source pending/enable/mode registers, lowest-index claim.
// Latency: one-cycle Wishbone ack; irq_i edge -> PENDING next edge -> irq_o/irq_id_o one edge later.
// Backpressure: a new access is accepted only when ack is low, so each access takes at least 2 cycles.
// Optional build macro WB_IRQ_CTRL_SWI_EN enables the software-set (SWSET) register at 0x10.
module wb_irq_ctrl #(
  parameter int N_IRQ = 16
) (
  input  logic             clk,
  input  logic             rstn_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [31:0]      wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  input  logic [N_IRQ-1:0] irq_i,
  output logic             irq_o,
  output logic [4:0]       irq_id_o
);

  // Word offsets decoded from wb_adr_i[4:2]
  localparam logic [2:0] SEL_PEND  = 3'd0;
  localparam logic [2:0] SEL_EN    = 3'd1;
  localparam logic [2:0] SEL_MODE  = 3'd2;
  localparam logic [2:0] SEL_CLAIM = 3'd3;
  localparam logic [2:0] SEL_SWSET = 3'd4;

  // Architectural state
  logic [N_IRQ-1:0] r_pending;
  logic [N_IRQ-1:0] r_enable;
  logic [N_IRQ-1:0] r_mode;      // 1 = edge, 0 = level
  logic [N_IRQ-1:0] r_prev;      // previous irq_i sample for edge detection
  logic             r_ack;
  logic [31:0]      r_dat;
  logic             r_irq;
  logic [4:0]       r_irq_id;

  // Bus decode
  logic             w_acc;
  logic             w_wr;
  logic             w_rd;
  logic [2:0]       w_sel;
  logic [N_IRQ-1:0] w_wdat;
  logic             w_unused_bits;

  // Interrupt datapath
  logic [N_IRQ-1:0] w_pe;
  logic             w_any;
  logic [4:0]       w_id;
  logic [N_IRQ-1:0] w_edge;
  logic [N_IRQ-1:0] w_w1c;
  logic [N_IRQ-1:0] w_claim_clr;
  logic [N_IRQ-1:0] w_swset;
  logic [N_IRQ-1:0] w_mode_nxt;
  logic [N_IRQ-1:0] w_lvl2edge;
  logic [N_IRQ-1:0] w_edge_set;
  logic [N_IRQ-1:0] w_edge_hold;
  logic [N_IRQ-1:0] w_pend_nxt;
  logic [31:0]      w_rdat;

  // An access is taken on any strobed cycle where the previous one is not being acked
  assign w_acc  = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr   = w_acc & wb_we_i;
  assign w_rd   = w_acc & ~wb_we_i;
  assign w_sel  = wb_adr_i[4:2];
  assign w_wdat = wb_dat_i[N_IRQ-1:0];

  // Address bits outside [4:2] and data bits above N_IRQ carry no meaning
  assign w_unused_bits = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i};

  assign w_pe   = r_pending & r_enable;
  assign w_any  = |w_pe;
  assign w_edge = irq_i & ~r_prev;

  // Lowest-numbered pending-and-enabled source; scanning downward lets the lowest index win
  always_comb begin
    w_id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_pe[i]) w_id = 5'(i);
    end
  end

  // Clear sources: W1C on PENDING and the bit named by a CLAIM read
  always_comb begin
    w_w1c       = '0;
    w_claim_clr = '0;
    if (w_wr && (w_sel == SEL_PEND)) w_w1c = w_wdat;
    for (int i = 0; i < N_IRQ; i++) begin
      w_claim_clr[i] = w_rd && (w_sel == SEL_CLAIM) && w_any && (w_id == 5'(i));
    end
  end

  // Software set is only a real register when the option is compiled in
  always_comb begin
    w_swset = '0;
`ifdef WB_IRQ_CTRL_SWI_EN
    if (w_wr && (w_sel == SEL_SWSET)) w_swset = w_wdat;
`else
    w_swset = '0;
`endif
  end

  // Pending next-state: edge bits set-dominant over clears, level bits follow irq_i,
  // and a bit switching level->edge starts out clear
  always_comb begin
    w_mode_nxt  = r_mode;
    if (w_wr && (w_sel == SEL_MODE)) w_mode_nxt = w_wdat;
    w_lvl2edge  = w_mode_nxt & ~r_mode;
    w_edge_set  = w_edge | w_swset;
    w_edge_hold = r_pending & ~(w_w1c | w_claim_clr);
    w_pend_nxt  = ((r_mode & (w_edge_set | w_edge_hold)) | (~r_mode & irq_i)) & ~w_lvl2edge;
  end

  // Read data mux; bits at or above N_IRQ read as zero via zero-extension
  always_comb begin
    w_rdat = '0;
    case (w_sel)
      SEL_PEND:  w_rdat = 32'(r_pending);
      SEL_EN:    w_rdat = 32'(r_enable);
      SEL_MODE:  w_rdat = 32'(r_mode);
      SEL_CLAIM: w_rdat = {w_any, 26'b0, w_id};
      default:   w_rdat = '0;
    endcase
  end

  // Bus handshake and register file update; read data is held only for the ack cycle
  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_enable <= '0;
      r_mode   <= '0;
    end else begin
      r_ack  <= w_acc;
      r_dat  <= w_rd ? w_rdat : 32'd0;
      r_mode <= w_mode_nxt;
      if (w_wr && (w_sel == SEL_EN)) r_enable <= w_wdat;
    end
  end

  // Source sampling and pending state
  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      r_prev    <= '0;
      r_pending <= '0;
    end else begin
      r_prev    <= irq_i;
      r_pending <= w_pend_nxt;
    end
  end

  // Registered interrupt outputs, one edge behind PENDING
  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      r_irq    <= 1'b0;
      r_irq_id <= '0;
    end else begin
      r_irq    <= w_any;
      r_irq_id <= w_id;
    end
  end

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;
  assign irq_o    = r_irq;
  assign irq_id_o = r_irq_id;

endmodule

// File: tb/tb_wb_irq_ctrl.sv
// Scoreboard bench for wb_irq_ctrl: stimulus queues expected read data and irq outputs,
// a negedge monitor pops and compares on each read ack or irq sample request.
// Directed vectors cover reset, edge/level modes, claim order, set priority and SWSET.
module tb_wb_irq_ctrl;
  localparam int N = 16;

  logic          clk = 1'b0;
  logic          rstn_i;
  logic          wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0]   wb_adr_i, wb_dat_i;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o;
  logic [N-1:0]  irq_i;
  logic          irq_o;
  logic [4:0]    irq_id_o;

  int n_chk = 0;
  int n_fail = 0;
  int n_acc = 0;
  int n_ack = 0;

  logic [31:0] q_rd[$];
  string       q_rd_nm[$];
  logic [5:0]  q_irq[$];
  string       q_irq_nm[$];
  logic        chk_irq_flag = 1'b0;
  logic        tb_we_q = 1'b0;

  wb_irq_ctrl #(.N_IRQ(N)) dut (
    .clk      (clk),
    .rstn_i   (rstn_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .irq_i    (irq_i),
    .irq_o    (irq_o),
    .irq_id_o (irq_id_o)
  );

  always #5 clk = ~clk;

  // remember direction of the access being acked
  always @(posedge clk) begin
    if (wb_cyc_i && wb_stb_i) tb_we_q <= wb_we_i;
  end

  // monitor: compare read data on ack, irq outputs on request
  always @(negedge clk) begin
    logic [31:0] exp_d;
    logic [5:0]  exp_i;
    string       nm;
    if (wb_ack_o) begin
      n_ack++;
      if (!tb_we_q) begin
        n_chk++;
        if (q_rd.size() == 0) begin
          n_fail++;
          $display("FAIL rd_unexpected: read ack with nothing queued, data %h", wb_dat_o);
        end else begin
          exp_d = q_rd.pop_front();
          nm    = q_rd_nm.pop_front();
          if (wb_dat_o !== exp_d) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, wb_dat_o, exp_d);
          end
        end
      end
    end
    if (chk_irq_flag) begin
      n_chk++;
      if (q_irq.size() == 0) begin
        n_fail++;
        $display("FAIL irq_unexpected: sample request with nothing queued");
      end else begin
        exp_i = q_irq.pop_front();
        nm    = q_irq_nm.pop_front();
        if ({irq_o, irq_id_o} !== exp_i) begin
          n_fail++;
          $display("FAIL %s: got irq_o=%b id=%0d expected irq_o=%b id=%0d",
                   nm, irq_o, irq_id_o, exp_i[5], exp_i[4:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    int  lat;
    bit  got;
    if (wb_ack_o) step();
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    n_acc++;
    lat = 0;
    got = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (wb_ack_o) begin
        got = 1'b1;
        lat = c;
        break;
      end
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    n_chk++;
    if (!got || lat != 1) begin
      n_fail++;
      $display("FAIL ack_latency adr %h: got %0d cycles (0 = none in 8), expected 1", adr, lat);
    end
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
    wb(1'b1, adr, dat);
  endtask

  task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string nm);
    q_rd.push_back(exp);
    q_rd_nm.push_back(nm);
    wb(1'b0, adr, 32'd0);
  endtask

  task automatic chk(input logic exp_o, input logic [4:0] exp_id, input string nm);
    q_irq.push_back({exp_o, exp_id});
    q_irq_nm.push_back(nm);
    chk_irq_flag = 1'b1;
    step();
    chk_irq_flag = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn_i   = 1'b0;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_adr_i = '0;
    wb_dat_i = '0;
    irq_i    = '0;
    repeat (3) step();
    rstn_i = 1'b1;

    // reset state: irq outputs low, every offset reads zero
    chk(1'b0, 5'd0, "rst_irq");
    for (int a = 0; a < 8; a++) rd(32'(a * 4), 32'd0, "rst_rd");

    // unmapped offsets ignore writes and read zero
    wr(32'h14, 32'hFFFF_FFFF);
    wr(32'h1C, 32'hFFFF_FFFF);
    rd(32'h14, 32'd0, "unmapped_14");
    rd(32'h04, 32'd0, "unmapped_no_alias_en");
    rd(32'h08, 32'd0, "unmapped_no_alias_mode");

    // edge source 2: latency and W1C
    wr(32'h04, 32'h4);
    wr(32'h08, 32'h4);
    rd(32'h04, 32'h4, "en_rb");
    irq_i[2] = 1'b1;
    step();
    irq_i[2] = 1'b0;
    chk(1'b0, 5'd0, "edge2_k");
    chk(1'b1, 5'd2, "edge2_k1");
    rd(32'h00, 32'h4, "edge2_pend");
    wr(32'h00, 32'h4);
    chk(1'b1, 5'd2, "w1c_lag");
    chk(1'b0, 5'd0, "w1c_clr");
    rd(32'h00, 32'h0, "w1c_pend");

    // claim ordering with two pending sources
    wr(32'h08, 32'hFFFF);
    wr(32'h04, 32'h28);
    irq_i[3] = 1'b1;
    irq_i[5] = 1'b1;
    step();
    irq_i = '0;
    step();
    rd(32'h00, 32'h28, "claim_pend");
    rd(32'h0C, 32'h8000_0003, "claim3");
    rd(32'h0C, 32'h8000_0005, "claim5");
    rd(32'h0C, 32'h0000_0000, "claim_none");
    rd(32'h00, 32'h0, "claim_pend_after");

    // level source 0: W1C has no effect, follows input
    wr(32'h08, 32'h0);
    wr(32'h04, 32'h1);
    irq_i[0] = 1'b1;
    step();
    step();
    rd(32'h00, 32'h1, "lvl_pend");
    wr(32'h00, 32'h1);
    rd(32'h00, 32'h1, "lvl_w1c");
    rd(32'h0C, 32'h8000_0000, "lvl_claim");
    rd(32'h00, 32'h1, "lvl_claim_keep");
    irq_i[0] = 1'b0;
    chk(1'b1, 5'd0, "lvl_drop_0");
    chk(1'b1, 5'd0, "lvl_drop_1");
    chk(1'b0, 5'd0, "lvl_drop_2");

    // set priority: new edge on bit 1 coincides with W1C of bit 1
    wr(32'h08, 32'h2);
    wr(32'h04, 32'h2);
    irq_i[1] = 1'b1;
    step();
    irq_i[1] = 1'b0;
    step();
    rd(32'h00, 32'h2, "e1_pend");
    step();
    irq_i[1] = 1'b1;
    wr(32'h00, 32'h2);
    irq_i[1] = 1'b0;
    rd(32'h00, 32'h2, "set_prio");
    wr(32'h00, 32'h2);
    rd(32'h00, 32'h0, "w1c_plain");

    // software set on edge-mode bit 7
    wr(32'h08, 32'h80);
    wr(32'h04, 32'h80);
    wr(32'h10, 32'h80);
    step();
`ifdef WB_IRQ_CTRL_SWI_EN
    chk(1'b1, 5'd7, "swi_irq");
    rd(32'h00, 32'h80, "swi_pend");
`else
    chk(1'b0, 5'd0, "swi_off_irq");
    rd(32'h00, 32'h0, "swi_off_pend");
`endif
    rd(32'h10, 32'h0, "swset_rd");

    // reset aborts an in-flight access; input held high across reset
    irq_i[4] = 1'b1;
    step();
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = 1'b1;
    wb_adr_i = 32'h04;
    wb_dat_i = 32'hFFFF;
    rstn_i   = 1'b0;
    step();
    n_chk++;
    if (wb_ack_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_abort_ack: got %b expected 0", wb_ack_o);
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    chk(1'b0, 5'd0, "rst2_irq");
    rstn_i = 1'b1;
    step();
    rd(32'h04, 32'h0, "rst2_en");
    rd(32'h08, 32'h0, "rst2_mode");
    rd(32'h00, 32'h10, "rst2_lvl_pend");
    wr(32'h08, 32'h10);
    step();
    rd(32'h00, 32'h0, "rst2_no_edge");
    irq_i = '0;

    repeat (3) step();
    n_chk++;
    if (q_rd.size() != 0 || q_irq.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d reads and %0d irq samples left, expected 0", q_rd.size(), q_irq.size());
    end
    n_chk++;
    if (n_ack != n_acc) begin
      n_fail++;
      $display("FAIL ack_count: got %0d acks expected %0d", n_ack, n_acc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
